// File: rtl/fifo_defines_pkg.sv
// Shared definitions for the sample FIFO path: sample width and the
// reader's state encoding.
package fifo_defines_pkg;

  localparam int DATA_WIDTH = 16;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_READ = 3'd2;
  localparam logic [2:0] S_CAP  = 3'd3;
  localparam logic [2:0] S_PRES = 3'd4;

  typedef enum logic [2:0] {
    IDLE = S_IDLE,
    WAIT = S_WAIT,
    READ = S_READ,
    CAP  = S_CAP,
    PRES = S_PRES
  } rd_state_t;

  // True while a popped sample is still travelling towards the output stage.
  function automatic logic is_fetching(input rd_state_t s);
    return (s == READ) || (s == CAP) || (s == PRES);
  endfunction

endpackage

// File: rtl/rate_tick_gen.sv
// Programmable rate tick: one tick every div_q+1 cycles while running.
// The divider is latched on load so a running period never changes.
module rate_tick_gen #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run_i,
  input  logic                 load_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  output logic                 tick_o
);

  logic [DIV_WIDTH-1:0] r_cnt;
  logic [DIV_WIDTH-1:0] r_div_q;
  logic                 w_wrap;

  assign w_wrap = (r_cnt == r_div_q);
  assign tick_o = run_i && w_wrap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_div_q <= '0;
    end else if (load_i) begin
      r_div_q <= div_i;
      r_cnt   <= '0;
    end else if (!run_i || w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + {{(DIV_WIDTH-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/fifo_sample_reader.sv
// Consumer end of the sample FIFO: pops at a programmable rate, presents each
// sample on a valid/ready stream and flags underflow / overrun events.
module fifo_sample_reader #(
  parameter int DATA_WIDTH = fifo_defines_pkg::DATA_WIDTH,
  parameter int DIV_WIDTH  = 16,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en_i,
  input  logic [DIV_WIDTH-1:0]         div_i,
  input  logic                         empty_i,
  output logic                         rd_en_o,
  input  logic signed [DATA_WIDTH-1:0] data_i,
  output logic signed [DATA_WIDTH-1:0] sample_o,
  output logic                         sample_valid_o,
  input  logic                         sample_ready_i,
  output logic                         underflow_o,
  output logic                         overrun_o,
  output logic [CNT_WIDTH-1:0]         uflow_cnt_o,
  output logic                         busy_o
);

  import fifo_defines_pkg::*;

  rd_state_t r_state;
  rd_state_t w_state_next;

  logic w_tick;
  logic w_service;
  logic w_load;
  logic w_run;
  logic r_pend;
  logic w_pend_next;
  logic r_underflow;
  logic w_underflow_next;
  logic r_overrun;
  logic w_overrun_next;

  logic signed [DATA_WIDTH-1:0] r_sample;
  logic [CNT_WIDTH-1:0]         r_uflow_cnt;

  assign w_run     = (r_state != IDLE);
  assign w_load    = (r_state == IDLE) && en_i;
  assign w_service = w_tick | r_pend;

  rate_tick_gen #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_rate_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .run_i  (w_run),
    .load_i (w_load),
    .div_i  (div_i),
    .tick_o (w_tick)
  );

  always_comb begin
    w_state_next     = r_state;
    w_pend_next      = r_pend;
    w_underflow_next = 1'b0;
    w_overrun_next   = 1'b0;

    // While a fetch is in flight one tick can be remembered; any further one is lost.
    if (is_fetching(r_state) && w_tick) begin
      if (r_pend) begin
        w_overrun_next = 1'b1;
      end else begin
        w_pend_next = 1'b1;
      end
    end

    case (r_state)
      IDLE: begin
        w_pend_next = 1'b0;
        if (en_i) begin
          w_state_next = WAIT;
        end
      end
      WAIT: begin
        if (!en_i) begin
          w_state_next = IDLE;
          w_pend_next  = 1'b0;
        end else if (w_service) begin
          w_pend_next = 1'b0;
          if (!empty_i) begin
            w_state_next = READ;
          end else begin
            w_underflow_next = 1'b1;
          end
        end
      end
      READ: begin
        w_state_next = CAP;
      end
      CAP: begin
        w_state_next = PRES;
      end
      PRES: begin
        if (sample_ready_i) begin
          if (en_i) begin
            w_state_next = WAIT;
          end else begin
            w_state_next = IDLE;
            w_pend_next  = 1'b0;
          end
        end
      end
      default: begin
        w_state_next = IDLE;
        w_pend_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_pend      <= 1'b0;
      r_underflow <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_pend      <= w_pend_next;
      r_underflow <= w_underflow_next;
      r_overrun   <= w_overrun_next;
    end
  end

  // FIFO read data arrives the cycle after the pop strobe, i.e. in CAP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sample <= '0;
    end else if (r_state == CAP) begin
      r_sample <= data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_uflow_cnt <= '0;
    end else if (w_underflow_next && (r_uflow_cnt != {CNT_WIDTH{1'b1}})) begin
      r_uflow_cnt <= r_uflow_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign rd_en_o        = (r_state == READ);
  assign sample_valid_o = (r_state == PRES);
  assign busy_o         = (r_state != IDLE);
  assign sample_o       = r_sample;
  assign underflow_o    = r_underflow;
  assign overrun_o      = r_overrun;
  assign uflow_cnt_o    = r_uflow_cnt;

endmodule

// File: tb/tb_fifo_sample_reader.sv
// Bench for fifo_sample_reader: directed scenarios plus a random run, all
// compared cycle by cycle against a behavioural model of the reader.
module tb_fifo_sample_reader;

  localparam int DW   = 16;
  localparam int DIVW = 16;
  localparam int CW   = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            en_i;
  logic [DIVW-1:0] div_i;
  logic            empty_i;
  logic            rd_en_o;
  logic [DW-1:0]   data_i;
  logic [DW-1:0]   sample_o;
  logic            sample_valid_o;
  logic            sample_ready_i;
  logic            underflow_o;
  logic            overrun_o;
  logic [CW-1:0]   uflow_cnt_o;
  logic            busy_o;

  fifo_sample_reader #(
    .DATA_WIDTH(DW),
    .DIV_WIDTH (DIVW),
    .CNT_WIDTH (CW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .en_i           (en_i),
    .div_i          (div_i),
    .empty_i        (empty_i),
    .rd_en_o        (rd_en_o),
    .data_i         (data_i),
    .sample_o       (sample_o),
    .sample_valid_o (sample_valid_o),
    .sample_ready_i (sample_ready_i),
    .underflow_o    (underflow_o),
    .overrun_o      (overrun_o),
    .uflow_cnt_o    (uflow_cnt_o),
    .busy_o         (busy_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Bench-side FIFO contents feeding empty_i / data_i.
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] accepted[$];

  // Behavioural model: running flag, fetch age (0 none, 1 pop, 2 capture,
  // 3 presenting), one remembered tick, and the period fixed at start.
  bit            m_active;
  int            m_fetch;
  bit            m_pend;
  int            m_period;
  int            m_phase;
  logic [DW-1:0] m_sample;
  int            m_cnt;
  bit            m_under;
  bit            m_over;

  int cyc;
  int last_rd;
  int rd_interval;
  int n_rd_seen;
  int n_under_seen;
  int n_over_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_fetch  = 0;
    m_pend   = 1'b0;
    m_period = 1;
    m_phase  = 0;
    m_sample = '0;
    m_cnt    = 0;
    m_under  = 1'b0;
    m_over   = 1'b0;
  endtask

  task automatic compare_all();
    check("rd_en", rd_en_o, m_fetch == 1);
    check("valid", sample_valid_o, m_fetch == 3);
    check("busy", busy_o, m_active);
    check("underflow", underflow_o, m_under);
    check("overrun", overrun_o, m_over);
    check("uflow_cnt", uflow_cnt_o, m_cnt);
    check("sample", sample_o, m_sample);
  endtask

  // Advance one clock from mid-cycle: update the model from the inputs
  // present at the edge, feed the FIFO, then compare.
  task automatic step();
    bit pre_rd;
    bit tick;
    bit nu;
    bit no;
    empty_i = (fifo_q.size() == 0);
    pre_rd  = rd_en_o;
    if (sample_valid_o && sample_ready_i) accepted.push_back(sample_o);

    tick = m_active && ((m_phase % m_period) == (m_period - 1));
    nu = 1'b0;
    no = 1'b0;
    if (!m_active) begin
      if (en_i) begin
        m_active = 1'b1;
        m_period = int'(div_i) + 1;
        m_phase  = 0;
      end
    end else begin
      m_phase++;
      if (m_fetch == 0) begin
        if (!en_i) begin
          m_active = 1'b0;
          m_pend   = 1'b0;
        end else if (tick || m_pend) begin
          m_pend = 1'b0;
          if (!empty_i) m_fetch = 1;
          else begin
            nu = 1'b1;
            if (m_cnt < 255) m_cnt++;
          end
        end
      end else begin
        if (tick) begin
          if (m_pend) no = 1'b1;
          else m_pend = 1'b1;
        end
        if (m_fetch == 1) m_fetch = 2;
        else if (m_fetch == 2) begin
          m_fetch  = 3;
          m_sample = data_i;
        end else if (sample_ready_i) begin
          m_fetch = 0;
          if (!en_i) begin
            m_active = 1'b0;
            m_pend   = 1'b0;
          end
        end
      end
    end
    m_under = nu;
    m_over  = no;

    @(posedge clk);
    #1;
    cyc++;
    if (pre_rd) data_i = (fifo_q.size() > 0) ? fifo_q.pop_front() : '0;
    empty_i = (fifo_q.size() == 0);
    compare_all();
    if (rd_en_o) begin
      n_rd_seen++;
      rd_interval = cyc - last_rd;
      last_rd     = cyc;
    end
    if (underflow_o) n_under_seen++;
    if (overrun_o) n_over_seen++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    rst = 1'b0;
    compare_all();
    n_rd_seen = 0;
    n_under_seen = 0;
    n_over_seen = 0;
    accepted.delete();
  endtask

  task automatic run_until_reads(input int n, input int bound, input string tag);
    int got;
    got = 0;
    for (int i = 0; i < bound && got < n; i++) begin
      step();
      if (rd_en_o) got++;
    end
    check(tag, got, n);
  endtask

  task automatic run_until_valid(input int bound, input string tag);
    int i;
    i = 0;
    while (!sample_valid_o && i < bound) begin
      step();
      i++;
    end
    check(tag, sample_valid_o, 1'b1);
  endtask

  initial begin
    rst = 1'b0;
    en_i = 1'b0;
    div_i = '0;
    empty_i = 1'b1;
    data_i = '0;
    sample_ready_i = 1'b0;
    cyc = 0;
    last_rd = 0;
    rd_interval = 0;
    #2;
    do_reset();

    // 1: three samples at div 3, always ready
    fifo_q = '{16'd10, 16'hFFEC, 16'd30};
    div_i = 16'd3;
    sample_ready_i = 1'b1;
    en_i = 1'b1;
    run_until_reads(2, 20, "t1_first_reads");
    check("t1_period_a", rd_interval, 4);
    run_until_reads(1, 20, "t1_third_read");
    check("t1_period_b", rd_interval, 4);
    for (int i = 0; i < 6; i++) step();
    check("t1_count", accepted.size(), 3);
    if (accepted.size() == 3) begin
      check("t1_s0", accepted[0], 16'd10);
      check("t1_s1", accepted[1], 16'hFFEC);
      check("t1_s2", accepted[2], 16'd30);
    end
    check("t1_reads", n_rd_seen, 3);

    // 2: empty FIFO, tick every cycle for 300 cycles
    en_i = 1'b0;
    do_reset();
    fifo_q.delete();
    div_i = 16'd0;
    en_i = 1'b1;
    for (int i = 0; i < 301; i++) step();
    check("t2_underflows", n_under_seen, 300);
    check("t2_sat", uflow_cnt_o, 8'd255);
    check("t2_no_reads", n_rd_seen, 0);

    // 3: downstream stalls, ticks pile up
    en_i = 1'b0;
    do_reset();
    fifo_q = '{16'h1234, 16'h8001, 16'h0042, 16'h7FFF, 16'h0003};
    div_i = 16'd1;
    sample_ready_i = 1'b0;
    en_i = 1'b1;
    run_until_valid(20, "t3_first_valid");
    for (int i = 0; i < 20; i++) step();
    check("t3_hold", sample_o, 16'h1234);
    check("t3_overrun_seen", n_over_seen > 0, 1'b1);
    sample_ready_i = 1'b1;
    step();
    check("t3_accept_busy", busy_o, 1'b1);
    step();
    check("t3_pend_pop", rd_en_o, 1'b1);

    // 4: enable dropped during capture
    en_i = 1'b0;
    do_reset();
    fifo_q = '{16'h0BEE, 16'h0002, 16'h0003};
    div_i = 16'd2;
    sample_ready_i = 1'b1;
    en_i = 1'b1;
    run_until_reads(1, 20, "t4_read");
    step();
    en_i = 1'b0;
    n_rd_seen = 0;
    for (int i = 0; i < 10; i++) step();
    check("t4_accepted", accepted.size(), 1);
    if (accepted.size() == 1) check("t4_value", accepted[0], 16'h0BEE);
    check("t4_idle", busy_o, 1'b0);
    check("t4_no_reads", n_rd_seen, 0);

    // 5: reset while presenting
    do_reset();
    fifo_q = '{16'h5A5A, 16'h0101};
    div_i = 16'd0;
    sample_ready_i = 1'b0;
    en_i = 1'b1;
    run_until_valid(20, "t5_valid");
    check("t5_sample_pre", sample_o, 16'h5A5A);
    en_i = 1'b0;
    do_reset();

    // 6: divider change only takes effect after IDLE
    fifo_q.delete();
    for (int i = 0; i < 10; i++) fifo_q.push_back(16'(100 + i));
    div_i = 16'd5;
    sample_ready_i = 1'b1;
    en_i = 1'b1;
    run_until_reads(2, 40, "t6_reads_a");
    check("t6_period_a", rd_interval, 6);
    div_i = 16'd1;
    run_until_reads(2, 40, "t6_reads_b");
    check("t6_period_kept", rd_interval, 6);
    en_i = 1'b0;
    for (int i = 0; i < 6; i++) step();
    check("t6_idle", busy_o, 1'b0);
    div_i = 16'd7;
    en_i = 1'b1;
    run_until_reads(2, 40, "t6_reads_c");
    check("t6_period_new", rd_interval, 8);

    // Random run against the model
    en_i = 1'b0;
    do_reset();
    fifo_q.delete();
    for (int i = 0; i < 2000; i++) begin
      en_i = ($urandom_range(0, 99) < 95);
      sample_ready_i = ($urandom_range(0, 99) < 70);
      if ($urandom_range(0, 19) == 0) div_i = 16'($urandom_range(0, 6));
      if ($urandom_range(0, 3) == 0) fifo_q.push_back(16'($urandom));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
